instr_mem_param: RTL and testbench

Parametrised, synchronous-read instruction memory for the pipelined MIPS fetch stage, replacing the fixed-size single-cycle instruction store. It gives a registered instruction and PC to the IF/ID boundary and supports stall and flush from the hazard unit. It detects out-of-range and misaligned fetches and substitutes a NOP. A write-only load port preloads programs, and a saturating counter records retired fetches for performance checks.

---
 rtl/instr_mem_param.sv | 97 +++++++++
 tb/tb_instr_mem_param.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/instr_mem_param.sv
// Synchronous-read instruction store for the IF/ID boundary: registered word and PC,
// stall/flush handling, fault-to-NOP substitution, program load port and retired-fetch counter.
module instr_mem_param #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 32,
  parameter int          BYTE_ADDR = 1,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        instruction,
  output logic [ADDR_W-1:0]        pc_out,
  output logic                     instr_valid,
  output logic                     addr_fault,
  output logic                     align_fault,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [CNT_W-1:0]         fetch_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTE_ADDR != 0) ? $clog2(BYTES) : 0;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_WORD);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              cnt_full;

  // Range test uses the full index; the truncated mem_idx is only a read port address.
  assign idx          = address >> OFF_W;
  assign mem_idx      = idx[IDX_W-1:0];
  assign misaligned   = (BYTE_ADDR != 0) && ((address & ADDR_W'(BYTES - 1)) != '0);
  assign out_of_range = (idx >> IDX_W) != '0;
  assign cnt_full     = &fetch_count;

  // Load port ignores rst/stall/flush so programs can be preloaded under reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= NOP;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
      align_fault <= 1'b0;
      fetch_count <= '0;
    end else if (flush) begin
      instruction <= NOP;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
      align_fault <= 1'b0;
    end else if (!stall) begin
      if (fetch_en) begin
        pc_out      <= address;
        instr_valid <= 1'b1;
        if (misaligned) begin
          instruction <= NOP;
          align_fault <= 1'b1;
          addr_fault  <= 1'b0;
        end else if (out_of_range) begin
          instruction <= NOP;
          align_fault <= 1'b0;
          addr_fault  <= 1'b1;
        end else begin
          // Old word is read here while a same-edge load lands in mem.
          instruction <= mem[mem_idx];
          align_fault <= 1'b0;
          addr_fault  <= 1'b0;
          if (!cnt_full) begin
            fetch_count <= fetch_count + 1'b1;
          end
        end
      end else begin
        instr_valid <= 1'b0;
        addr_fault  <= 1'b0;
        align_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_param.sv
// Directed plus randomized bench for instr_mem_param, checked against an
// array-based reference model; a second instance with CNT_W=2 checks saturation.
module tb_instr_mem_param;

  logic        clk = 1'b0;
  logic        rst, fetch_en, stall, flush, ld_we;
  logic [31:0] address, ld_data;
  logic [5:0]  ld_addr;

  logic [31:0] instruction, pc_out, instruction2, pc_out2;
  logic        instr_valid, addr_fault, align_fault;
  logic        instr_valid2, addr_fault2, align_fault2;
  logic [15:0] fetch_count;
  logic [1:0]  fetch_count2;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem [64];
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_af, m_alf;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  instr_mem_param dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .address(address), .instruction(instruction), .pc_out(pc_out),
    .instr_valid(instr_valid), .addr_fault(addr_fault), .align_fault(align_fault),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_count(fetch_count)
  );

  instr_mem_param #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .address(address), .instruction(instruction2), .pc_out(pc_out2),
    .instr_valid(instr_valid2), .addr_fault(addr_fault2), .align_fault(align_fault2),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_count(fetch_count2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic fe, input logic st, input logic fl,
                            input logic [31:0] a, input logic lwe, input logic [5:0] la,
                            input logic [31:0] ld);
    if (r) begin
      m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_af = 1'b0; m_alf = 1'b0;
      m_cnt = 0; m_cnt2 = 0;
    end else if (fl) begin
      m_instr = 32'h0; m_valid = 1'b0; m_af = 1'b0; m_alf = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (fe) begin
      m_pc = a; m_valid = 1'b1;
      if (a % 4 != 0) begin
        m_instr = 32'h0; m_alf = 1'b1; m_af = 1'b0;
      end else if (a / 4 >= 64) begin
        m_instr = 32'h0; m_alf = 1'b0; m_af = 1'b1;
      end else begin
        m_instr = m_mem[a / 4]; m_alf = 1'b0; m_af = 1'b0;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else begin
      m_valid = 1'b0; m_af = 1'b0; m_alf = 1'b0;
    end
    if (lwe) m_mem[la] = ld;
  endtask

  task automatic step(input logic r, input logic fe, input logic st, input logic fl,
                      input logic [31:0] a, input logic lwe, input logic [5:0] la,
                      input logic [31:0] ld, input string tag);
    rst = r; fetch_en = fe; stall = st; flush = fl; address = a;
    ld_we = lwe; ld_addr = la; ld_data = ld;
    @(posedge clk);
    model_edge(r, fe, st, fl, a, lwe, la, ld);
    @(negedge clk);
    chk({tag, ".instr"}, 64'(instruction), 64'(m_instr));
    chk({tag, ".pc"}, 64'(pc_out), 64'(m_pc));
    chk({tag, ".valid"}, 64'(instr_valid), 64'(m_valid));
    chk({tag, ".addr_fault"}, 64'(addr_fault), 64'(m_af));
    chk({tag, ".align_fault"}, 64'(align_fault), 64'(m_alf));
    chk({tag, ".count"}, 64'(fetch_count), 64'(m_cnt));
    chk({tag, ".count_sat"}, 64'(fetch_count2), 64'(m_cnt2));
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    rst = 1'b1; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; address = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset held 3 cycles while a fetch is requested
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'd4, 0, 6'd0, 32'd0, "reset");

    // Preload every word so random fetches always hit known data
    for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 32'd0, 1, 6'(i), $urandom(), "preload");
    step(0, 0, 0, 0, 32'd0, 1, 6'd1, 32'h2010_0005, "load1");
    step(0, 1, 0, 0, 32'd4, 0, 6'd0, 32'd0, "fetch4");
    chk("fetch4.literal", 64'(instruction), 64'h2010_0005);

    step(0, 1, 0, 0, 32'h100, 0, 6'd0, 32'd0, "oor");
    step(0, 1, 0, 0, 32'd6, 0, 6'd0, 32'd0, "misalign");
    step(0, 1, 0, 0, 32'h106, 0, 6'd0, 32'd0, "both_faults");

    step(0, 1, 0, 0, 32'd4, 0, 6'd0, 32'd0, "pre_stall");
    step(0, 1, 1, 0, 32'd8, 0, 6'd0, 32'd0, "stall1");
    step(0, 1, 1, 0, 32'd8, 0, 6'd0, 32'd0, "stall2");
    chk("stall2.literal", 64'(instruction), 64'h2010_0005);
    step(0, 1, 1, 1, 32'd8, 0, 6'd0, 32'd0, "flush_stall");
    step(0, 0, 0, 0, 32'd0, 0, 6'd0, 32'd0, "idle");

    // Same-index load/fetch collision: old word first, new word on refetch
    step(0, 0, 0, 0, 32'd0, 1, 6'd2, 32'hAAAA_0000, "preload2");
    step(0, 1, 0, 0, 32'd8, 1, 6'd2, 32'hBBBB_0000, "collide");
    chk("collide.literal", 64'(instruction), 64'hAAAA_0000);
    step(0, 1, 0, 0, 32'd8, 0, 6'd0, 32'd0, "refetch");
    chk("refetch.literal", 64'(instruction), 64'hBBBB_0000);

    step(1, 1, 0, 0, 32'd12, 0, 6'd0, 32'd0, "midrst");
    step(0, 1, 0, 0, 32'd4, 0, 6'd0, 32'd0, "post_rst");
    chk("post_rst.literal", 64'(instruction), 64'h2010_0005);

    // Five valid fetches: the 2-bit counter must stick at 3
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 32'(i * 4 + 16), 0, 6'd0, 32'd0, "sat");
    chk("sat.literal", 64'(fetch_count2), 64'd3);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = 32'($urandom_range(0, 63) * 4);
      else if (sel <= 7) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else               a = $urandom();
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8), a,
           ($urandom_range(0, 99) < 30), 6'($urandom_range(0, 63)), $urandom(), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
